hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Sequences the IF/ID pipeline register and PC of the 16-bit five-stage pipeline: detects load-use and branch-operand hazards, inserts one- or two-cycle stalls, flushes the fetched instruction on a taken branch, freezes the whole pipe during cache misses, and latches halt. It sits beside the decode stage and drives the write-enable, stall-reassert and noop inputs of the IF/ID register plus the bubble input of ID/EX.

## Interface
Parameters:
- none (register file is fixed at 16 x 16-bit; register 0 is hard-wired zero)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- IDRs, IDRt  in  4  source registers of the instruction in ID
- IDUsesRs, IDUsesRt  in  1  the ID instruction actually reads that source
- IDIsBranchReg  in  1  ID instruction is a register-target branch (operand needed in ID)
- IDHalt  in  1  ID instruction is HLT (already cleared by IF/ID when noop'd)
- BranchTaken  in  1  branch resolved taken in ID this cycle
- EXRd  in  4  destination of instruction in EX
- EXRegWrite, EXMemRead  in  1  EX instruction writes a register / is a load
- IMissBusy, DMissBusy  in  1  instruction / data cache miss in progress
- PCWriteEnable  out  1  PC may advance
- IFIDWriteEnable  out  1  write enable of IF/ID register
- IFIDStall  out  1  stall-reassert request into IF/ID
- IFIDNoop  out  1  flush fetched instruction (noop into IF/ID)
- IDEXBubble  out  1  insert bubble into ID/EX
- PipeFreeze  out  1  hold EX/MEM and MEM/WB
- Halted  out  1  processor halted

## Operation
- State register: RUN, HOLD (one more forced stall owed), HALT. Outputs are combinational from state and inputs.
- Match(r) = IDUses(r) & EXRegWrite & (EXRd == r) & (EXRd != 0), evaluated for Rs and Rt.
- Priority each cycle: rst > miss freeze > HALT > HOLD > hazard detection > branch flush > halt detection.
- Miss freeze (IMissBusy | DMissBusy): PipeFreeze=1, PCWriteEnable=0, IFIDWriteEnable=0, IDEXBubble=0, IFIDNoop=0; state does not change (a pending HOLD is not consumed).
- HALT: PCWriteEnable=0, IFIDWriteEnable=0, IDEXBubble=1, Halted=1; exits only on rst.
- HOLD: PCWriteEnable=0, IFIDWriteEnable=0, IDEXBubble=1; next state RUN.
- Hazard in RUN: load-use (EXMemRead & Match) or branch-operand (IDIsBranchReg & Match). Stall: PCWriteEnable=0, IFIDWriteEnable=0, IDEXBubble=1. If IDIsBranchReg & EXMemRead & Match: two stalls, IFIDStall=1, next state HOLD; otherwise one stall, stay RUN.
- BranchTaken ignored whenever a stall or freeze is issued that cycle. Otherwise, taken: IFIDNoop=1, PCWriteEnable=1, IFIDWriteEnable=1.
- IDHalt with no stall/freeze: PCWriteEnable=0, IFIDWriteEnable=0, next state HALT.
- Default RUN: PCWriteEnable=1, IFIDWriteEnable=1, all others 0.

## Timing
- While rst high: state RUN; PCWriteEnable, IFIDWriteEnable, IFIDStall, IFIDNoop, IDEXBubble, PipeFreeze, Halted all 0. First cycle after release: RUN defaults.
- Hazard detection latency 0 (same cycle as operands in ID/EX); state update on rising clk.
- Load feeding register branch: exactly 2 bubble cycles; ALU result feeding register branch or any load-use: exactly 1.
- Miss arriving during HOLD: freeze cycles inserted, HOLD stall still issued after miss clears.
- rst mid-HOLD or mid-HALT: immediate return to RUN behaviour after release.

## Configuration
- STALL_PERF_EN: when defined, adds output StallCycles (16 bit), counting cycles with IDEXBubble=1 or PipeFreeze=1, saturating at 16'hFFFF, cleared by rst. When undefined, the port and counter are absent; all other behaviour identical.

## Test plan
- Load r3 in EX (EXRd=3, EXMemRead=1), ID add reads Rs=3 -> one cycle PCWriteEnable=0, IDEXBubble=1; next cycle defaults.
- Load r5 in EX, ID register branch on r5 -> IFIDStall=1, two consecutive bubble cycles, then RUN.
- ID reads r0 with EXRd=0, EXMemRead=1 -> no stall.
- BranchTaken=1, no hazard -> IFIDNoop=1 for one cycle; BranchTaken=1 with branch-operand hazard -> IFIDNoop=0, stall.
- Enter HOLD, assert DMissBusy 3 cycles -> PipeFreeze=1 for 3 cycles, then one HOLD bubble.
- IDHalt=1 -> Halted=1 next cycle, stays until rst; with STALL_PERF_EN, StallCycles increments every halted cycle.

Source files
------------

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_controller
// Summary  : IF/ID and PC sequencing for the 16-bit five-stage pipeline:
//            load-use / branch-operand stalls, branch flush, miss freeze, halt.
//            Optional macro STALL_PERF_EN adds the StallCycles counter output.
// Revision : 1.0  initial release
// ============================================================================
module hazard_stall_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  IDRs,
    input  logic [3:0]  IDRt,
    input  logic        IDUsesRs,
    input  logic        IDUsesRt,
    input  logic        IDIsBranchReg,
    input  logic        IDHalt,
    input  logic        BranchTaken,
    input  logic [3:0]  EXRd,
    input  logic        EXRegWrite,
    input  logic        EXMemRead,
    input  logic        IMissBusy,
    input  logic        DMissBusy,
`ifdef STALL_PERF_EN
    output logic [15:0] StallCycles,
`endif
    output logic        PCWriteEnable,
    output logic        IFIDWriteEnable,
    output logic        IFIDStall,
    output logic        IFIDNoop,
    output logic        IDEXBubble,
    output logic        PipeFreeze,
    output logic        Halted
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic match_rs;
    logic match_rt;
    logic match_any;
    logic load_use;
    logic branch_dep;
    logic two_stall;
    logic miss;

    // Register 0 is hard-wired zero, so a write to it never creates a dependency.
    assign match_rs   = IDUsesRs & EXRegWrite & (EXRd == IDRs) & (EXRd != 4'd0);
    assign match_rt   = IDUsesRt & EXRegWrite & (EXRd == IDRt) & (EXRd != 4'd0);
    assign match_any  = match_rs | match_rt;
    assign load_use   = EXMemRead & match_any;
    assign branch_dep = IDIsBranchReg & match_any;
    assign two_stall  = IDIsBranchReg & EXMemRead & match_any;
    assign miss       = IMissBusy | DMissBusy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        PCWriteEnable   = 1'b0;
        IFIDWriteEnable = 1'b0;
        IFIDStall       = 1'b0;
        IFIDNoop        = 1'b0;
        IDEXBubble      = 1'b0;
        PipeFreeze      = 1'b0;
        Halted          = (state_q == HALT);

        if (miss) begin
            // Whole pipe holds; a pending HOLD stall survives the miss.
            PipeFreeze = 1'b1;
        end else if (state_q == HALT) begin
            IDEXBubble = 1'b1;
        end else if (state_q == HOLD) begin
            IDEXBubble = 1'b1;
            state_d    = RUN;
        end else if (load_use | branch_dep) begin
            IDEXBubble = 1'b1;
            if (two_stall) begin
                IFIDStall = 1'b1;
                state_d   = HOLD;
            end
        end else if (BranchTaken) begin
            IFIDNoop        = 1'b1;
            PCWriteEnable   = 1'b1;
            IFIDWriteEnable = 1'b1;
        end else if (IDHalt) begin
            state_d = HALT;
        end else begin
            PCWriteEnable   = 1'b1;
            IFIDWriteEnable = 1'b1;
        end

        // Outputs are quiet for the whole time reset is held, not just at the edge.
        if (rst) begin
            PCWriteEnable   = 1'b0;
            IFIDWriteEnable = 1'b0;
            IFIDStall       = 1'b0;
            IFIDNoop        = 1'b0;
            IDEXBubble      = 1'b0;
            PipeFreeze      = 1'b0;
            Halted          = 1'b0;
        end
    end

`ifdef STALL_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((IDEXBubble | PipeFreeze) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCycles = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_controller
// Summary  : Directed self-checking bench for hazard_stall_controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_stall_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  IDRs, IDRt, EXRd;
    logic        IDUsesRs, IDUsesRt, IDIsBranchReg, IDHalt, BranchTaken;
    logic        EXRegWrite, EXMemRead, IMissBusy, DMissBusy;
    logic        PCWriteEnable, IFIDWriteEnable, IFIDStall, IFIDNoop;
    logic        IDEXBubble, PipeFreeze, Halted;
`ifdef STALL_PERF_EN
    logic [15:0] StallCycles;
`endif

    int n_checks;
    int n_fail;

    // {PCWriteEnable, IFIDWriteEnable, IFIDStall, IFIDNoop, IDEXBubble, PipeFreeze, Halted}
    logic [6:0] obs;
    assign obs = {PCWriteEnable, IFIDWriteEnable, IFIDStall, IFIDNoop,
                  IDEXBubble, PipeFreeze, Halted};

    localparam logic [6:0] C_RUN    = 7'b1100000;
    localparam logic [6:0] C_STALL1 = 7'b0000100;
    localparam logic [6:0] C_STALL2 = 7'b0010100;
    localparam logic [6:0] C_HOLD   = 7'b0000100;
    localparam logic [6:0] C_FREEZE = 7'b0000010;
    localparam logic [6:0] C_FLUSH  = 7'b1101000;
    localparam logic [6:0] C_HLTDET = 7'b0000000;
    localparam logic [6:0] C_HALTED = 7'b0000101;
    localparam logic [6:0] C_QUIET  = 7'b0000000;

    hazard_stall_controller dut (
        .clk             (clk),
        .rst             (rst),
        .IDRs            (IDRs),
        .IDRt            (IDRt),
        .IDUsesRs        (IDUsesRs),
        .IDUsesRt        (IDUsesRt),
        .IDIsBranchReg   (IDIsBranchReg),
        .IDHalt          (IDHalt),
        .BranchTaken     (BranchTaken),
        .EXRd            (EXRd),
        .EXRegWrite      (EXRegWrite),
        .EXMemRead       (EXMemRead),
        .IMissBusy       (IMissBusy),
        .DMissBusy       (DMissBusy),
`ifdef STALL_PERF_EN
        .StallCycles     (StallCycles),
`endif
        .PCWriteEnable   (PCWriteEnable),
        .IFIDWriteEnable (IFIDWriteEnable),
        .IFIDStall       (IFIDStall),
        .IFIDNoop        (IFIDNoop),
        .IDEXBubble      (IDEXBubble),
        .PipeFreeze      (PipeFreeze),
        .Halted          (Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        IDRs = 4'd0; IDRt = 4'd0; EXRd = 4'd0;
        IDUsesRs = 1'b0; IDUsesRt = 1'b0; IDIsBranchReg = 1'b0;
        IDHalt = 1'b0; BranchTaken = 1'b0;
        EXRegWrite = 1'b0; EXMemRead = 1'b0;
        IMissBusy = 1'b0; DMissBusy = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        #2 rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        n_checks++;
        if (obs !== C_QUIET) begin
            n_fail++;
            $display("FAIL reset_held: got %b expected %b", obs, C_QUIET);
        end
        step();
        n_checks++;
        if (obs !== C_QUIET) begin
            n_fail++;
            $display("FAIL reset_after_edge: got %b expected %b", obs, C_QUIET);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== C_RUN) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", obs, C_RUN);
        end
        step();
    endtask

    task automatic test_load_use();
        clear_inputs();
        EXRd = 4'd3; EXRegWrite = 1'b1; EXMemRead = 1'b1;
        IDRs = 4'd3; IDUsesRs = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_STALL1) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b expected %b", obs, C_STALL1);
        end
        step();
        clear_inputs();
        IDRs = 4'd3; IDUsesRs = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_RUN) begin
            n_fail++;
            $display("FAIL load_use_release: got %b expected %b", obs, C_RUN);
        end
        // Same register named but not actually read: no dependency.
        clear_inputs();
        EXRd = 4'd3; EXRegWrite = 1'b1; EXMemRead = 1'b1;
        IDRs = 4'd3; IDRt = 4'd3;
        #1;
        n_checks++;
        if (obs !== C_RUN) begin
            n_fail++;
            $display("FAIL load_use_unused_src: got %b expected %b", obs, C_RUN);
        end
        step();
    endtask

    task automatic test_r0();
        clear_inputs();
        EXRd = 4'd0; EXRegWrite = 1'b1; EXMemRead = 1'b1;
        IDRs = 4'd0; IDUsesRs = 1'b1; IDRt = 4'd0; IDUsesRt = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_RUN) begin
            n_fail++;
            $display("FAIL r0_no_stall: got %b expected %b", obs, C_RUN);
        end
        step();
    endtask

    task automatic test_branch_load();
        clear_inputs();
        EXRd = 4'd5; EXRegWrite = 1'b1; EXMemRead = 1'b1;
        IDRt = 4'd5; IDUsesRt = 1'b1; IDIsBranchReg = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_STALL2) begin
            n_fail++;
            $display("FAIL br_load_first: got %b expected %b", obs, C_STALL2);
        end
        step();
        clear_inputs();
        IDRt = 4'd5; IDUsesRt = 1'b1; IDIsBranchReg = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_HOLD) begin
            n_fail++;
            $display("FAIL br_load_second: got %b expected %b", obs, C_HOLD);
        end
        step();
        #1;
        n_checks++;
        if (obs !== C_RUN) begin
            n_fail++;
            $display("FAIL br_load_release: got %b expected %b", obs, C_RUN);
        end
        step();
    endtask

    task automatic test_alu_branch();
        clear_inputs();
        EXRd = 4'd7; EXRegWrite = 1'b1;
        IDRs = 4'd7; IDUsesRs = 1'b1; IDIsBranchReg = 1'b1; BranchTaken = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_STALL1) begin
            n_fail++;
            $display("FAIL alu_branch_stall: got %b expected %b", obs, C_STALL1);
        end
        step();
        clear_inputs();
        #1;
        n_checks++;
        if (obs !== C_RUN) begin
            n_fail++;
            $display("FAIL alu_branch_single: got %b expected %b", obs, C_RUN);
        end
        step();
    endtask

    task automatic test_branch_flush();
        clear_inputs();
        EXRd = 4'd2; EXRegWrite = 1'b1;
        IDRs = 4'd9; IDUsesRs = 1'b1; IDIsBranchReg = 1'b1; BranchTaken = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_FLUSH) begin
            n_fail++;
            $display("FAIL branch_flush: got %b expected %b", obs, C_FLUSH);
        end
        step();
        clear_inputs();
        #1;
        n_checks++;
        if (obs !== C_RUN) begin
            n_fail++;
            $display("FAIL branch_flush_next: got %b expected %b", obs, C_RUN);
        end
        step();
    endtask

    task automatic test_hold_miss();
        clear_inputs();
        EXRd = 4'd4; EXRegWrite = 1'b1; EXMemRead = 1'b1;
        IDRs = 4'd4; IDUsesRs = 1'b1; IDIsBranchReg = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_STALL2) begin
            n_fail++;
            $display("FAIL hold_miss_enter: got %b expected %b", obs, C_STALL2);
        end
        step();
        clear_inputs();
        DMissBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (obs !== C_FREEZE) begin
                n_fail++;
                $display("FAIL hold_miss_freeze%0d: got %b expected %b", i, obs, C_FREEZE);
            end
            step();
        end
        DMissBusy = 1'b0;
        #1;
        n_checks++;
        if (obs !== C_HOLD) begin
            n_fail++;
            $display("FAIL hold_miss_bubble: got %b expected %b", obs, C_HOLD);
        end
        step();
        #1;
        n_checks++;
        if (obs !== C_RUN) begin
            n_fail++;
            $display("FAIL hold_miss_release: got %b expected %b", obs, C_RUN);
        end
        step();
    endtask

    task automatic test_reset_mid_hold();
        clear_inputs();
        EXRd = 4'd6; EXRegWrite = 1'b1; EXMemRead = 1'b1;
        IDRs = 4'd6; IDUsesRs = 1'b1; IDIsBranchReg = 1'b1;
        step();
        clear_inputs();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== C_RUN) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got %b expected %b", obs, C_RUN);
        end
        step();
    endtask

    task automatic test_halt();
        pulse_reset();
`ifdef STALL_PERF_EN
        n_checks++;
        if (StallCycles !== 16'd0) begin
            n_fail++;
            $display("FAIL perf_cleared: got %0d expected 0", StallCycles);
        end
`endif
        IDHalt = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_HLTDET) begin
            n_fail++;
            $display("FAIL halt_detect: got %b expected %b", obs, C_HLTDET);
        end
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (obs !== C_HALTED) begin
                n_fail++;
                $display("FAIL halt_hold%0d: got %b expected %b", i, obs, C_HALTED);
            end
            step();
        end
`ifdef STALL_PERF_EN
        n_checks++;
        if (StallCycles !== 16'd3) begin
            n_fail++;
            $display("FAIL perf_halt_count: got %0d expected 3", StallCycles);
        end
`endif
        BranchTaken = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_HALTED) begin
            n_fail++;
            $display("FAIL halt_ignores_branch: got %b expected %b", obs, C_HALTED);
        end
        clear_inputs();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== C_QUIET) begin
            n_fail++;
            $display("FAIL halt_reset_held: got %b expected %b", obs, C_QUIET);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== C_RUN) begin
            n_fail++;
            $display("FAIL halt_reset_release: got %b expected %b", obs, C_RUN);
        end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_load_use();
        test_r0();
        test_branch_load();
        test_alu_branch();
        test_branch_flush();
        test_hold_miss();
        test_reset_mid_hold();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
